hamming_scrub_counter: RTL and testbench
========================================

# hamming_scrub_counter

Parametrised successor of the team's Hamming-protected 32-bit counter. It counts while `enable` is high. When counting stops, the value is encoded per 4-bit block with Hamming(7,4) check bits. While the counter is idle, a scrub state machine periodically checks the stored value, corrects single-bit upsets, counts corrections, and (optionally) flags double errors. It sits wherever an SEU-hardened event/state counter is needed, and also exposes an error-injection port for radiation-test campaigns.

## Interface
- `WIDTH`, 32, counter width; must be a multiple of 4.
- `BLOCKS`, `WIDTH/4`, number of protected nibbles (derived).
- `SCRUB_PERIOD`, 16, idle cycles between scrub passes (≥2).
- `ERR_CNT_W`, 8, width of the correction counter.
- `clk`, in, 1, single clock; all flops are on the rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `enable`, in, 1, increment per cycle while high.
- `load_valid`, in, 1, load `load_value` into the counter.
- `load_value`, in, `WIDTH`, preset value.
- `inj_valid`, in, 1, apply the injection masks this cycle.
- `inj_data_mask`, in, `WIDTH`, XOR mask applied to the stored count.
- `inj_par_mask`, in, `BLOCKS*3`, XOR mask applied to the stored check bits.
- `counter`, out, `WIDTH`, current count.
- `protected_o`, out, 1, check bits are valid for `counter`.
- `busy`, out, 1, scrub pass in progress (CHECK or FIX).
- `corr_pulse`, out, 1, one-cycle pulse when a pass corrected at least one bit.
- `uncorr_pulse`, out, 1, one-cycle pulse on a detected double error.
- `uncorr_sticky`, out, 1, set by `uncorr_pulse`; cleared only by reset.
- `err_count`, out, `ERR_CNT_W`, saturating count of correcting passes.

## Operation
- **States:**
  - RUN: counting.
  - ENCODE: one cycle, compute check bits.
  - IDLE: protected, period timer running.
  - CHECK: register the syndromes.
  - FIX: write back corrections.
- **Check bits per block i** (data bits d0..d3 = `counter[4i+0..3]`):
  - p0 = d0^d2^d3
  - p1 = d0^d1^d3
  - p2 = d0^d1^d2
  - Syndrome s = {s2,s1,s0} = stored p XOR recomputed p.
- **Decode:**
  - 111 flips d0; 110 flips d1; 101 flips d2; 011 flips d3.
  - 001, 010, 100: check-bit error; regenerate the check bits, data unchanged.
  - 000: clean.
- **Priority:** `load_valid` > `enable` > scrub.
  - Load from any state: `counter`=`load_value`, next state ENCODE.
  - `enable` high in any state (including CHECK/FIX): go to RUN and increment from the current, uncorrected value; the pass is abandoned with no pulses; `protected_o`=0.
- **Enable falls:** RUN → ENCODE → IDLE.
- **Timer:** restarts on IDLE entry; after `SCRUB_PERIOD` cycles go to CHECK, then FIX, then IDLE.
- **In FIX:**
  - All blocks are corrected in parallel.
  - `corr_pulse` fires if any block was corrected.
  - `err_count` increments by 1 per pass, not per block, and saturates at all-ones.
- **Injection:** honoured only outside RUN/ENCODE; ignored otherwise. Masks XOR into the stored data and check bits. State is unchanged.
- **Wrap-around:** all-ones + 1 = 0, with no flag.

## Timing
- Reset values:
  - `counter`=0, check bits=0 (consistent with 0), state IDLE, timer=0.
  - `protected_o`=1.
  - `busy`, `corr_pulse`, `uncorr_pulse`, `uncorr_sticky`=0.
  - `err_count`=0.
- Increment is visible on the edge where `enable`=1 is sampled.
- `protected_o` rises 2 edges after the first edge sampling `enable`=0 (ENCODE, then IDLE).
- Worst-case latency from an injection edge to the corrected `counter`: `SCRUB_PERIOD`+2 cycles.
- `busy` is high exactly during CHECK and FIX.
- `corr_pulse` and `uncorr_pulse` are registered and high for the cycle after FIX.
- Reset asserted mid-pass: immediate return to reset values; pulses are not generated.

## Configuration
- **`HC_DED_EN` defined:**
  - Adds one overall parity bit q per block (XOR of d0..d3 and p0..p2); extended Hamming(8,4).
  - `inj_par_mask` grows to `BLOCKS*4`, with the q bit at offset 3.
  - Decode rules:
    - Nonzero s with q mismatch: single error, correct it.
    - Nonzero s with q match: double error; that block is left untouched and `uncorr_pulse`=1.
    - s=0 with q mismatch: q-bit error, regenerate it.
- **`HC_DED_EN` undefined:**
  - SEC only; double errors are miscorrected silently.
  - `uncorr_pulse` and `uncorr_sticky` are tied to 0.

## Structure
- Package `hc_pkg`:
  - State enum.
  - Check-bit count constant (3 or 4 per block, depending on `HC_DED_EN`).
  - `hc_encode` and `hc_decode` functions; `hc_decode` returns the corrected nibble plus a status enum {CLEAN, DATA_FIX, PAR_FIX, DOUBLE}.
- Sub-module `hamming_nibble_codec`: combinational encode/decode for one block, generated `BLOCKS` times.
- Top level: FSM, timer, counter, stored check bits, statistics.

## Test plan
- Reset, then `enable` for 5 cycles → `counter`=5; `protected_o` high 2 cycles after `enable` falls.
- `load_value`=0xFFFFFFFE, then `enable` for 3 cycles → `counter`=1 (wrap).
- Idle with `counter`=0x12345678, inject `inj_data_mask`=0x00000010 → within 18 cycles `counter`=0x12345678, one `corr_pulse`, `err_count`=1.
- Inject 0x80000001 (two blocks) → both bits restored in one pass; `err_count` increments by exactly 1.
- With `HC_DED_EN`, inject 0x00000003 → `uncorr_pulse`=1, `uncorr_sticky`=1, block 0 unchanged (still corrupted), `err_count` unchanged.
- Inject at the start of CHECK, then raise `enable` → no pulses; counting continues from the corrupted value; 300 forced passes → `err_count` saturates at 255.

Source files
------------

// File: rtl/hamming_scrub_counter_pkg.sv
// Shared types and Hamming(7,4) / extended (8,4) helpers for the scrubbed counter.
// Defining HC_DED_EN adds an overall parity bit per nibble for double-error detection.
package hc_pkg;

`ifdef HC_DED_EN
    localparam int HC_CHK_BITS = 4;
`else
    localparam int HC_CHK_BITS = 3;
`endif

    typedef logic [2:0] hc_state_t;

    localparam hc_state_t ST_RUN    = 3'd0;
    localparam hc_state_t ST_ENCODE = 3'd1;
    localparam hc_state_t ST_IDLE   = 3'd2;
    localparam hc_state_t ST_CHECK  = 3'd3;
    localparam hc_state_t ST_FIX    = 3'd4;

    typedef enum logic [1:0] {
        CLEAN    = 2'd0,
        DATA_FIX = 2'd1,
        PAR_FIX  = 2'd2,
        DOUBLE   = 2'd3
    } hc_status_e;

    typedef struct packed {
        logic [3:0]             data;
        logic [HC_CHK_BITS-1:0] chk;
        hc_status_e             status;
    } hc_decode_t;

    // Check bits: [0]=p0, [1]=p1, [2]=p2 and, with DED, [3]=overall parity q.
    function automatic logic [HC_CHK_BITS-1:0] hc_encode(input logic [3:0] d);
        logic [HC_CHK_BITS-1:0] c;
        c[0] = d[0] ^ d[2] ^ d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[1] ^ d[2];
`ifdef HC_DED_EN
        c[3] = (^d) ^ c[0] ^ c[1] ^ c[2];
`endif
        return c;
    endfunction

    function automatic hc_decode_t hc_decode(input logic [3:0] d,
                                             input logic [HC_CHK_BITS-1:0] c);
        hc_decode_t             r;
        logic [HC_CHK_BITS-1:0] e;
        logic [2:0]             s;
        logic [3:0]             flip;
        e = hc_encode(d);
        s = c[2:0] ^ e[2:0];
        case (s)
            3'b111:  flip = 4'b0001;
            3'b110:  flip = 4'b0010;
            3'b101:  flip = 4'b0100;
            3'b011:  flip = 4'b1000;
            default: flip = 4'b0000;
        endcase
        r.data   = d;
        r.chk    = c;
        r.status = CLEAN;
`ifdef HC_DED_EN
        // With q matching, a nonzero syndrome can only come from two flipped bits.
        if (s == 3'b000) begin
            if (^{d, c}) begin
                r.chk    = e;
                r.status = PAR_FIX;
            end
        end else if (!(^{d, c})) begin
            r.status = DOUBLE;
        end else begin
            r.data   = d ^ flip;
            r.chk    = hc_encode(d ^ flip);
            r.status = (flip != 4'b0000) ? DATA_FIX : PAR_FIX;
        end
`else
        if (s != 3'b000) begin
            r.data   = d ^ flip;
            r.chk    = hc_encode(d ^ flip);
            r.status = (flip != 4'b0000) ? DATA_FIX : PAR_FIX;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/hamming_scrub_counter_nibble_codec.sv
// Combinational encoder/decoder for one protected nibble of the scrubbed counter.
module hamming_nibble_codec
    import hc_pkg::*;
(
    input  logic [3:0]             data,
    input  logic [HC_CHK_BITS-1:0] chk,
    output logic [HC_CHK_BITS-1:0] enc,
    output logic [3:0]             fixed_data,
    output logic [HC_CHK_BITS-1:0] fixed_chk,
    output hc_status_e             status
);

    hc_decode_t dec;

    assign enc        = hc_encode(data);
    assign dec        = hc_decode(data, chk);
    assign fixed_data = dec.data;
    assign fixed_chk  = dec.chk;
    assign status     = dec.status;

endmodule

// File: rtl/hamming_scrub_counter.sv
// SEU-hardened counter: Hamming-protected per nibble, periodically scrubbed while idle.
// Defining HC_DED_EN enables double-error detection (uncorr_pulse / uncorr_sticky).
module hamming_scrub_counter
    import hc_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int BLOCKS       = WIDTH / 4,
    parameter int SCRUB_PERIOD = 16,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            load_valid,
    input  logic [WIDTH-1:0]                load_value,
    input  logic                            inj_valid,
    input  logic [WIDTH-1:0]                inj_data_mask,
    input  logic [BLOCKS*HC_CHK_BITS-1:0]   inj_par_mask,
    output logic [WIDTH-1:0]                counter,
    output logic                            protected_o,
    output logic                            busy,
    output logic                            corr_pulse,
    output logic                            uncorr_pulse,
    output logic                            uncorr_sticky,
    output logic [ERR_CNT_W-1:0]            err_count
);

    localparam int CW = BLOCKS * HC_CHK_BITS;
    localparam int TW = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;

    hc_state_t       state;
    logic [TW-1:0]   timer;
    logic [WIDTH-1:0] cnt, eff_data, dec_data, fix_data;
    logic [CW-1:0]   chk, eff_chk, enc_chk, dec_chk, fix_chk;
    hc_status_e      dec_status [BLOCKS];
    logic            scrub_state, inj_active;
    logic            any_corr, fix_corr;

    assign scrub_state = (state == ST_IDLE) || (state == ST_CHECK) || (state == ST_FIX);
    assign inj_active  = inj_valid && scrub_state;

    // Decoders see the stored word with this cycle's injection already applied,
    // so an upset injected during CHECK is caught by the same pass.
    assign eff_data = inj_active ? (cnt ^ inj_data_mask) : cnt;
    assign eff_chk  = inj_active ? (chk ^ inj_par_mask)  : chk;

    for (genvar b = 0; b < BLOCKS; b++) begin : g_blk
        hamming_nibble_codec u_codec (
            .data       (eff_data[4*b +: 4]),
            .chk        (eff_chk[HC_CHK_BITS*b +: HC_CHK_BITS]),
            .enc        (enc_chk[HC_CHK_BITS*b +: HC_CHK_BITS]),
            .fixed_data (dec_data[4*b +: 4]),
            .fixed_chk  (dec_chk[HC_CHK_BITS*b +: HC_CHK_BITS]),
            .status     (dec_status[b])
        );
    end

`ifdef HC_DED_EN
    logic any_double, fix_double, uncorr_pulse_q, uncorr_sticky_q;
`endif

    always_comb begin
        any_corr = 1'b0;
`ifdef HC_DED_EN
        any_double = 1'b0;
`endif
        for (int b = 0; b < BLOCKS; b++) begin
            if (dec_status[b] == DATA_FIX || dec_status[b] == PAR_FIX) any_corr = 1'b1;
`ifdef HC_DED_EN
            if (dec_status[b] == DOUBLE) any_double = 1'b1;
`endif
        end
    end

    // Load beats enable beats scrubbing; either of the first two abandons a pass silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            cnt        <= '0;
            chk        <= '0;
            fix_data   <= '0;
            fix_chk    <= '0;
            fix_corr   <= 1'b0;
            corr_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            corr_pulse <= 1'b0;
            if (load_valid) begin
                cnt   <= load_value;
                state <= ST_ENCODE;
            end else if (enable) begin
                cnt   <= cnt + WIDTH'(1);
                state <= ST_RUN;
            end else begin
                case (state)
                    ST_RUN: state <= ST_ENCODE;
                    ST_ENCODE: begin
                        chk   <= enc_chk;
                        timer <= '0;
                        state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        cnt <= eff_data;
                        chk <= eff_chk;
                        if (timer == TW'(SCRUB_PERIOD - 1)) state <= ST_CHECK;
                        else timer <= timer + TW'(1);
                    end
                    ST_CHECK: begin
                        cnt      <= eff_data;
                        chk      <= eff_chk;
                        fix_data <= dec_data;
                        fix_chk  <= dec_chk;
                        fix_corr <= any_corr;
                        state    <= ST_FIX;
                    end
                    ST_FIX: begin
                        cnt        <= inj_valid ? (fix_data ^ inj_data_mask) : fix_data;
                        chk        <= inj_valid ? (fix_chk ^ inj_par_mask) : fix_chk;
                        corr_pulse <= fix_corr;
                        if (fix_corr && (err_count != {ERR_CNT_W{1'b1}}))
                            err_count <= err_count + ERR_CNT_W'(1);
                        timer      <= '0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef HC_DED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fix_double      <= 1'b0;
            uncorr_pulse_q  <= 1'b0;
            uncorr_sticky_q <= 1'b0;
        end else begin
            uncorr_pulse_q <= 1'b0;
            if (!load_valid && !enable) begin
                if (state == ST_CHECK) fix_double <= any_double;
                if (state == ST_FIX && fix_double) begin
                    uncorr_pulse_q  <= 1'b1;
                    uncorr_sticky_q <= 1'b1;
                end
            end
        end
    end

    assign uncorr_pulse  = uncorr_pulse_q;
    assign uncorr_sticky = uncorr_sticky_q;
`else
    assign uncorr_pulse  = 1'b0;
    assign uncorr_sticky = 1'b0;
`endif

    assign counter     = cnt;
    assign protected_o = scrub_state;
    assign busy        = (state == ST_CHECK) || (state == ST_FIX);

endmodule

// File: tb/tb_hamming_scrub_counter.sv
// Directed bench for hamming_scrub_counter: vector table plus scrub/injection sequences.
`timescale 1ns/1ps
module tb_hamming_scrub_counter;
    import hc_pkg::*;

    localparam int WIDTH        = 32;
    localparam int BLOCKS       = WIDTH / 4;
    localparam int PW           = HC_CHK_BITS;
    localparam int SCRUB_PERIOD = 16;
    localparam int ERR_CNT_W    = 8;

    logic                   clk = 1'b0;
    logic                   reset, enable, load_valid, inj_valid;
    logic [WIDTH-1:0]       load_value, inj_data_mask;
    logic [BLOCKS*PW-1:0]   inj_par_mask;
    logic [WIDTH-1:0]       counter;
    logic                   protected_o, busy, corr_pulse, uncorr_pulse, uncorr_sticky;
    logic [ERR_CNT_W-1:0]   err_count;

    int checks = 0;
    int errors = 0;

    hamming_scrub_counter #(
        .WIDTH(WIDTH), .BLOCKS(BLOCKS), .SCRUB_PERIOD(SCRUB_PERIOD), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
        .load_value(load_value), .inj_valid(inj_valid), .inj_data_mask(inj_data_mask),
        .inj_par_mask(inj_par_mask), .counter(counter), .protected_o(protected_o),
        .busy(busy), .corr_pulse(corr_pulse), .uncorr_pulse(uncorr_pulse),
        .uncorr_sticky(uncorr_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [31:0] ld_val;
        logic        en;
        logic [31:0] exp_cnt;
        logic        exp_prot;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1 ns after the rising edge.
    task automatic applyStimulus(input logic ld, input logic [31:0] ldv, input logic en,
                                 input logic inj, input logic [31:0] dm,
                                 input logic [BLOCKS*PW-1:0] pm);
        load_valid    = ld;
        load_value    = ldv;
        enable        = en;
        inj_valid     = inj;
        inj_data_mask = dm;
        inj_par_mask  = pm;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        enable     = 1'b0;
        inj_valid  = 1'b0;
    endtask

    task automatic runIdle(input int n, input logic [31:0] target, output int corr_n,
                           output int uncorr_n, output int busy_n, output int first_hit);
        corr_n = 0; uncorr_n = 0; busy_n = 0; first_hit = -1;
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
            if (corr_pulse) corr_n++;
            if (uncorr_pulse) uncorr_n++;
            if (busy) busy_n++;
            if (first_hit < 0 && counter == target) first_hit = i;
        end
    endtask

    initial begin
        int corr_n, uncorr_n, busy_n, hit, exp_err, timeouts, waited;
        logic got;

        vecs[0]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h1,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[1]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h2,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[2]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h3,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[3]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h4,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[4]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h5,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[5]  = '{ld:1'b0, ld_val:32'h0,        en:1'b0, exp_cnt:32'h5,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[6]  = '{ld:1'b0, ld_val:32'h0,        en:1'b0, exp_cnt:32'h5,        exp_prot:1'b1, exp_busy:1'b0};
        vecs[7]  = '{ld:1'b1, ld_val:32'hFFFFFFFE, en:1'b0, exp_cnt:32'hFFFFFFFE, exp_prot:1'b0, exp_busy:1'b0};
        vecs[8]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'hFFFFFFFF, exp_prot:1'b0, exp_busy:1'b0};
        vecs[9]  = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h0,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[10] = '{ld:1'b0, ld_val:32'h0,        en:1'b1, exp_cnt:32'h1,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[11] = '{ld:1'b0, ld_val:32'h0,        en:1'b0, exp_cnt:32'h1,        exp_prot:1'b0, exp_busy:1'b0};
        vecs[12] = '{ld:1'b0, ld_val:32'h0,        en:1'b0, exp_cnt:32'h1,        exp_prot:1'b1, exp_busy:1'b0};
        vecs[13] = '{ld:1'b1, ld_val:32'h12345678, en:1'b1, exp_cnt:32'h12345678, exp_prot:1'b0, exp_busy:1'b0};
        vecs[14] = '{ld:1'b0, ld_val:32'h0,        en:1'b0, exp_cnt:32'h12345678, exp_prot:1'b1, exp_busy:1'b0};

        reset = 1'b1; enable = 1'b0; load_valid = 1'b0; inj_valid = 1'b0;
        load_value = '0; inj_data_mask = '0; inj_par_mask = '0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset counter", counter, 32'h0);
        checkOutput("reset protected_o", protected_o, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset corr_pulse", corr_pulse, 0);
        checkOutput("reset uncorr_sticky", uncorr_sticky, 0);
        checkOutput("reset err_count", err_count, 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].ld_val, vecs[i].en, 1'b0, 32'h0, '0);
            checkOutput($sformatf("vec%0d counter", i), counter, vecs[i].exp_cnt);
            checkOutput($sformatf("vec%0d protected_o", i), protected_o, vecs[i].exp_prot);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
        end

        // Single data-bit upset in nibble 1.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000010, '0);
        checkOutput("A injected value", counter, 32'h12345668);
        runIdle(40, 32'h12345678, corr_n, uncorr_n, busy_n, hit);
        exp_err++;
        checkOutput("A restore within period+2", (hit >= 1 && hit <= SCRUB_PERIOD + 2), 1);
        checkOutput("A counter", counter, 32'h12345678);
        checkOutput("A corr pulses", corr_n, 1);
        checkOutput("A busy cycles", busy_n, 4);
        checkOutput("A err_count", err_count, exp_err);

        // Two upsets in different nibbles, one pass.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h80000001, '0);
        checkOutput("B injected value", counter, 32'h92345679);
        runIdle(40, 32'h12345678, corr_n, uncorr_n, busy_n, hit);
        exp_err++;
        checkOutput("B counter", counter, 32'h12345678);
        checkOutput("B corr pulses", corr_n, 1);
        checkOutput("B err_count", err_count, exp_err);

        // Check-bit upset: data untouched, still a correcting pass.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, {{(BLOCKS*PW-1){1'b0}}, 1'b1});
        runIdle(40, 32'h12345678, corr_n, uncorr_n, busy_n, hit);
        exp_err++;
        checkOutput("P counter", counter, 32'h12345678);
        checkOutput("P corr pulses", corr_n, 1);
        checkOutput("P err_count", err_count, exp_err);

        // Double error in nibble 0.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000003, '0);
        runIdle(SCRUB_PERIOD + 2, 32'h1234567B, corr_n, uncorr_n, busy_n, hit);
`ifdef HC_DED_EN
        checkOutput("C uncorr pulses", uncorr_n, 1);
        checkOutput("C corr pulses", corr_n, 0);
        checkOutput("C uncorr_sticky", uncorr_sticky, 1);
`else
        exp_err++;
        checkOutput("C uncorr pulses", uncorr_n, 0);
        checkOutput("C corr pulses", corr_n, 1);
        checkOutput("C uncorr_sticky", uncorr_sticky, 0);
`endif
        checkOutput("C counter still corrupted", counter, 32'h1234567B);
        checkOutput("C err_count", err_count, exp_err);

        applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0, '0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        checkOutput("reload protected_o", protected_o, 1);

        // Injection at CHECK, then enable abandons the pass.
        got = 1'b0;
        for (int i = 0; i < 2 * (SCRUB_PERIOD + 2) && !got; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
            got = busy;
        end
        checkOutput("D reached CHECK", got, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000010, '0);
        checkOutput("D busy in FIX", busy, 1);
        checkOutput("D corrupted value", counter, 32'h12345668);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        checkOutput("D count from corrupted", counter, 32'h12345669);
        checkOutput("D corr_pulse", corr_pulse, 0);
        checkOutput("D protected_o", protected_o, 0);
        checkOutput("D busy", busy, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        checkOutput("D second increment", counter, 32'h1234566A);
        runIdle(4, 32'h1234566A, corr_n, uncorr_n, busy_n, hit);
        checkOutput("D no corr pulses", corr_n, 0);
        checkOutput("D no uncorr pulses", uncorr_n, 0);
        checkOutput("D err_count", err_count, exp_err);

        // Force 300 correcting passes.
        timeouts = 0;
        for (int p = 0; p < 300; p++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000001, '0);
            got = 1'b0;
            waited = 0;
            while (!got && waited < 2 * (SCRUB_PERIOD + 2)) begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
                got = corr_pulse;
                waited++;
            end
            if (!got) timeouts++;
            if (exp_err < 255) exp_err++;
        end
        checkOutput("S pass timeouts", timeouts, 0);
        checkOutput("S err_count saturated", err_count, exp_err);
        checkOutput("S err_count all-ones", err_count, 255);
        checkOutput("S counter", counter, 32'h1234566A);

        // Reset in the middle of a pass.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000100, '0);
        got = 1'b0;
        for (int i = 0; i < 2 * (SCRUB_PERIOD + 2) && !got; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
            got = busy;
        end
        checkOutput("R reached CHECK", got, 1);
        reset = 1'b1;
        #2;
        checkOutput("R counter", counter, 32'h0);
        checkOutput("R busy", busy, 0);
        checkOutput("R protected_o", protected_o, 1);
        checkOutput("R err_count", err_count, 0);
        checkOutput("R uncorr_sticky", uncorr_sticky, 0);
        reset = 1'b0;
        runIdle(3, 32'h0, corr_n, uncorr_n, busy_n, hit);
        checkOutput("R no corr pulses", corr_n, 0);
        checkOutput("R no uncorr pulses", uncorr_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
